// File: rtl/alu_arbiter_pkg.sv
// ============================================================================
// alu_arbiter_pkg : op codes, FSM encoding and counter width for alu_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

package alu_arbiter_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_OR  = 4'd2;
    localparam logic [3:0] OP_SLT = 4'd3;
    localparam logic [3:0] OP_LUI = 4'd4;

    localparam int         STATE_W = 2;
    localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] S_EXEC = 2'd1;
    localparam logic [STATE_W-1:0] S_RESP = 2'd2;

    localparam int         CNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/alu_arbiter_rr_pick.sv
// ============================================================================
// rr_pick : combinational 2-way round-robin picker, one-hot grant output
// Revision 1.0
// ============================================================================
`default_nettype none

module rr_pick (
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    output logic [1:0] grant_o
);

    // ptr_i names the requester preferred on contention; a lone valid always wins
    always_comb begin
        grant_o = valid_i;
        if (valid_i == 2'b11) begin
            grant_o = ptr_i ? 2'b10 : 2'b01;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// alu_arbiter : two requesters share one ALU through an IDLE/EXEC/RESP FSM.
// Optional per-requester completion counters when ALU_ARB_STATS_EN is defined.
// Revision 1.0
// ============================================================================
`default_nettype none

module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [31:0] req0_in1,
    input  logic [31:0] req0_in2,
    input  logic [31:0] req1_in1,
    input  logic [31:0] req1_in2,
    input  logic [3:0]  req0_alucon,
    input  logic [3:0]  req1_alucon,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_out,
    output logic        rsp_zero
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    logic [STATE_W-1:0] state_q, state_d;
    logic               ptr_q;
    logic [31:0]        in1_q, in2_q;
    logic [3:0]         op_q;
    logic               id_q;
    logic [31:0]        rsp_out_q;
    logic               rsp_zero_q;
    logic               rsp_id_q;

    logic [1:0]         w_grant;
    logic               w_accept;
    logic [31:0]        w_alu_res;
    logic               w_alu_zero;

    rr_pick u_rr_pick (
        .valid_i (({req1_valid, req0_valid})),
        .ptr_i   (ptr_q),
        .grant_o (w_grant)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_accept) state_d = S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Ready is masked while reset is held since IDLE is forced during reset
    always_comb begin
        req0_ready = (state_q == S_IDLE) && w_grant[0] && !reset;
        req1_ready = (state_q == S_IDLE) && w_grant[1] && !reset;
        rsp_valid  = (state_q == S_RESP);
    end

    assign w_accept = req0_ready | req1_ready;

    always_comb begin
        w_alu_res = 32'd0;
        case (op_q)
            OP_ADD:  w_alu_res = in1_q + in2_q;
            OP_SUB:  w_alu_res = in1_q - in2_q;
            OP_OR:   w_alu_res = in1_q | in2_q;
            OP_SLT:  w_alu_res = {31'd0, (in1_q < in2_q)};
            OP_LUI:  w_alu_res = {in2_q[15:0], 16'd0};
            default: w_alu_res = 32'd0;
        endcase
        w_alu_zero = (in1_q == in2_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q      <= 1'b0;
            in1_q      <= 32'd0;
            in2_q      <= 32'd0;
            op_q       <= 4'd0;
            id_q       <= 1'b0;
            rsp_out_q  <= 32'd0;
            rsp_zero_q <= 1'b0;
            rsp_id_q   <= 1'b0;
        end else begin
            if (w_accept) begin
                // After serving requester 0 prefer 1 next, and vice versa
                ptr_q <= w_grant[0];
                in1_q <= w_grant[1] ? req1_in1    : req0_in1;
                in2_q <= w_grant[1] ? req1_in2    : req0_in2;
                op_q  <= w_grant[1] ? req1_alucon : req0_alucon;
                id_q  <= w_grant[1];
            end
            if (state_q == S_EXEC) begin
                rsp_out_q  <= w_alu_res;
                rsp_zero_q <= w_alu_zero;
                rsp_id_q   <= id_q;
            end
        end
    end

    assign rsp_out  = rsp_out_q;
    assign rsp_zero = rsp_zero_q;
    assign rsp_id   = rsp_id_q;

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt1_q;
    logic             w_done;

    assign w_done = rsp_valid && rsp_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (w_done) begin
            if (!rsp_id_q && (cnt0_q != {CNT_W{1'b1}})) cnt0_q <= cnt0_q + 1'b1;
            if ( rsp_id_q && (cnt1_q != {CNT_W{1'b1}})) cnt1_q <= cnt1_q + 1'b1;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`else
    // Statistics counters are not built in this configuration
`endif

endmodule

`default_nettype wire
